// File: rtl/idct_pkg.sv
// Shared constants, FSM state type and row element helper for the row IDCT sequencer.
package idct_pkg;

    localparam int unsigned ROWS      = 8;
    localparam int unsigned ELEM_W    = 9;
    localparam int unsigned ROW_IN_W  = 64;
    localparam int unsigned ROW_OUT_W = 72;

    typedef enum logic [1:0] {FILL, FLUSH, DRAIN} state_e;

    // Element j of a result row; element 0 sits in the MSBs.
    function automatic logic [ELEM_W-1:0] elem(input logic [ROW_OUT_W-1:0] row,
                                               input logic [2:0]           j);
        return row[ROW_OUT_W-1-ELEM_W*j -: ELEM_W];
    endfunction

endpackage

// File: rtl/idct_row_seq_if.sv
// Stream and row-IDCT side-band signals of the row IDCT sequencer.
interface idct_row_seq_if;
    import idct_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [ROW_IN_W-1:0]  in_row;
    logic [ROW_IN_W-1:0]  idct_in;
    logic [ROW_OUT_W-1:0] idct_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [ROW_OUT_W-1:0] out_col;
    logic                 out_last;
    logic                 block_done;

    modport master (
        output in_valid, in_row, idct_out, out_ready,
        input  in_ready, idct_in, out_valid, out_col, out_last, block_done
    );

    modport slave (
        input  in_valid, in_row, idct_out, out_ready,
        output in_ready, idct_in, out_valid, out_col, out_last, block_done
    );

endinterface

// File: rtl/idct_tbuf.sv
// 8x72 transpose buffer: row write port, combinational column read port.
module idct_tbuf
    import idct_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [2:0]           i_waddr,
    input  logic [ROW_OUT_W-1:0] i_wdata,
    input  logic [2:0]           i_raddr,
    output logic [ROW_OUT_W-1:0] o_rdata
);

    logic [ROW_OUT_W-1:0] r_mem [ROWS];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Column raddr: element raddr of every row, row 0 in the MSBs.
    always_comb begin
        o_rdata = '0;
        for (int r = 0; r < ROWS; r++) begin
            o_rdata[ROW_OUT_W-1-ELEM_W*r -: ELEM_W] = elem(r_mem[r], i_raddr);
        end
    end

endmodule

// File: rtl/idct_row_seq.sv
// Row IDCT sequencer: feeds rows to the row IDCT, transposes results, streams columns out.
// Define IDCT_ROW_SEQ_PINGPONG_EN for two transpose buffers so filling overlaps draining.
module idct_row_seq
    import idct_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    idct_row_seq_if.slave bus
);

    logic [3:0]           r_row_cnt, r_col_cnt;
    logic                 r_cap_pend;
    logic [2:0]           r_cap_row;
    logic [ROW_IN_W-1:0]  r_idct_in;
    logic                 r_block_done;
    logic                 w_in_ready, w_out_valid, w_accept, w_out_hs;
    logic                 w_fill_last, w_drain_last;
    logic [ROW_OUT_W-1:0] w_col;

    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_out_hs     = w_out_valid & bus.out_ready;
    assign w_fill_last  = w_accept & (r_row_cnt == 4'd7);
    assign w_drain_last = w_out_hs & (r_col_cnt == 4'd7);

    assign bus.in_ready   = w_in_ready;
    assign bus.idct_in    = r_idct_in;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_col    = w_col;
    assign bus.out_last   = w_out_valid & (r_col_cnt == 4'd7);
    assign bus.block_done = r_block_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_cnt    <= '0;
            r_col_cnt    <= '0;
            r_cap_pend   <= 1'b0;
            r_cap_row    <= '0;
            r_idct_in    <= '0;
            r_block_done <= 1'b0;
        end else begin
            r_cap_pend   <= w_accept;
            r_block_done <= w_drain_last;
            if (w_accept) begin
                r_idct_in <= bus.in_row;
                r_cap_row <= r_row_cnt[2:0];
                r_row_cnt <= r_row_cnt + 4'd1;
            end
`ifdef IDCT_ROW_SEQ_PINGPONG_EN
            if (w_fill_last) r_row_cnt <= '0;
`else
            if (w_drain_last) r_row_cnt <= '0;
`endif
            if (w_drain_last) r_col_cnt <= '0;
            else if (w_out_hs) r_col_cnt <= r_col_cnt + 4'd1;
        end
    end

`ifdef IDCT_ROW_SEQ_PINGPONG_EN
    logic                 r_fill_sel, r_drain_sel, r_cap_sel;
    logic [1:0]           r_full;
    logic [ROW_OUT_W-1:0] w_rdata0, w_rdata1;

    assign w_out_valid = r_full[r_drain_sel];
    // A buffer emitting its last column may be refilled now: its row 0 lands a cycle later.
    assign w_in_ready  = !r_full[r_fill_sel] || ((r_drain_sel == r_fill_sel) && w_drain_last);
    assign w_col       = r_drain_sel ? w_rdata1 : w_rdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_sel  <= 1'b0;
            r_drain_sel <= 1'b0;
            r_cap_sel   <= 1'b0;
            r_full      <= '0;
        end else begin
            if (w_accept) r_cap_sel <= r_fill_sel;
            if (w_fill_last) r_fill_sel <= ~r_fill_sel;
            if (w_drain_last) begin
                r_full[r_drain_sel] <= 1'b0;
                r_drain_sel         <= ~r_drain_sel;
            end
            if (r_cap_pend && (r_cap_row == 3'd7)) r_full[r_cap_sel] <= 1'b1;
        end
    end

    idct_tbuf u_tbuf0 (
        .clk     (clk),
        .i_we    (r_cap_pend & ~r_cap_sel),
        .i_waddr (r_cap_row),
        .i_wdata (bus.idct_out),
        .i_raddr (r_col_cnt[2:0]),
        .o_rdata (w_rdata0)
    );

    idct_tbuf u_tbuf1 (
        .clk     (clk),
        .i_we    (r_cap_pend & r_cap_sel),
        .i_waddr (r_cap_row),
        .i_wdata (bus.idct_out),
        .i_raddr (r_col_cnt[2:0]),
        .o_rdata (w_rdata1)
    );
`else
    state_e r_state, w_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FILL:    if (w_fill_last) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_last) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            FILL:    w_in_ready = 1'b1;
            DRAIN:   w_out_valid = 1'b1;
            default: ;
        endcase
    end

    idct_tbuf u_tbuf (
        .clk     (clk),
        .i_we    (r_cap_pend),
        .i_waddr (r_cap_row),
        .i_wdata (bus.idct_out),
        .i_raddr (r_col_cnt[2:0]),
        .o_rdata (w_col)
    );
`endif

endmodule

// File: doc/idct_row_seq.md
Name: idct_row_seq

Overview:
- Sequencer for the combinational 1-D row IDCT stage: 64-bit row of eight 8-bit coefficients in, 72-bit row of eight 9-bit rounded results out.
- Accepts the 8 rows of one 8x8 block over a valid/ready stream and presents each row to the row IDCT.
- Captures each result into a transpose buffer, then streams the block out column by column for the second (column) IDCT pass.
- Sits between the dequantiser output and the column IDCT.

Parameters:
- ROWS, 8, rows per block and columns per block.
- ELEM_W, 9, width of one row-IDCT result element.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid and in_ready are both high
- in_row  in  64  coefficient row; element 0 in bits [63:56]
- idct_in  out  64  registered row driven to the row IDCT
- idct_out  in  72  row IDCT result; element j in bits [71-9j -: 9]
- out_valid  out  1  output column valid
- out_ready  in  1  downstream accept
- out_col  out  72  column c = {buf[0][c], buf[1][c], ..., buf[7][c]}; row 0 in MSBs
- out_last  out  1  high with column 7
- block_done  out  1  one-cycle pulse after column 7 handshake

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - State = FILL; row_cnt = 0; col_cnt = 0; cap_pend = 0.
  - idct_in = 0; in_ready = 1; out_valid = 0; out_last = 0; block_done = 0.
  - Buffer contents are not reset.
- States:
  - FILL:
    - in_ready = 1.
    - On accept: idct_in <= in_row; cap_pend <= 1; cap_row <= row_cnt; row_cnt++.
    - When the 8th row is accepted (row_cnt = 7): go to FLUSH.
  - FLUSH:
    - Lasts one cycle; in_ready = 0.
    - The last capture completes; then go to DRAIN.
  - DRAIN:
    - in_ready = 0; out_valid = 1.
    - out_col is built combinationally from buffer column col_cnt; out_last = (col_cnt = 7).
    - On handshake: col_cnt++.
    - On handshake with col_cnt = 7: col_cnt <= 0; row_cnt <= 0; block_done pulses next cycle; go to FILL.
- Capture timing:
  - A row accepted in cycle t is on idct_in in cycle t+1.
  - idct_out is written into buf[cap_row] at the end of cycle t+1 when cap_pend = 1.
  - cap_pend clears unless a new row was accepted in cycle t+1.
  - Back-to-back rows therefore give one capture per cycle.
- Latency and throughput:
  - Last input row accepted to first out_valid: 2 cycles.
  - Minimum block period: 8 + 1 + 8 = 17 cycles.
- Data handling:
  - The block does no arithmetic on data. All ELEM_W-bit elements are passed through bit-exact, including element 7, which the row IDCT drives as zero.
  - The 4-bit counters wrap only as described above; no other wrap-around occurs.
- Backpressure:
  - out_col and out_last are held stable while out_valid = 1 and out_ready = 0.
  - in_valid while in_ready = 0 is ignored, not lost; the upstream holds it.
- Reset mid-block: all state returns to the reset values immediately. Any partial block is discarded and no block_done is issued.

Optional Feature:
- Macro: IDCT_ROW_SEQ_PINGPONG_EN.
- Defined:
  - Two transpose buffers. FILL of buffer B proceeds while DRAIN of buffer A runs.
  - in_ready = 0 only when the fill buffer is complete and the other buffer is still draining.
  - Block period drops to 8 cycles in steady state; FLUSH overlaps with draining.
  - out_col always comes from the oldest complete buffer; blocks are output in input order.
- Undefined: single buffer; FILL, FLUSH and DRAIN are strictly serial as described above.

Decomposition:
- Shared package idct_pkg:
  - ROWS, ELEM_W, ROW_IN_W = 64, ROW_OUT_W = 72.
  - State enum {FILL, FLUSH, DRAIN}.
  - Element-slice helper function (element j of a 72-bit row).
- One sub-module, idct_tbuf:
  - 8x72 register array with a row write port (we, waddr, wdata).
  - Combinational column read port (raddr, 72-bit rdata).
  - Instanced twice under the macro.

Test Plan:
- Row IDCT connected.
  - Stimulus: row 0 = 64'h1000_0000_0000_0000 (DC = 16), rows 1-7 = 0, out_ready = 1.
  - Response: columns 0-6 = 72'h80_0000_0000_0000_0000, column 7 = 0, out_last only on column 7, block_done one cycle after.
- Stub idct_out = {idct_in, 8'h00}.
  - Stimulus: rows with distinct bytes 8'hRC.
  - Response: out_col bit-exact transpose.
  - Response: first out_valid exactly 2 cycles after the 8th in_valid&in_ready.
- Backpressure.
  - Stimulus: out_ready = 0 for 5 cycles during column 3.
  - Response: out_col stable; in_ready = 0 throughout DRAIN; no column skipped or repeated.
- Gapped input.
  - Stimulus: in_valid toggling 1,0,1,0.
  - Response: still exactly 8 captures into rows 0-7 in order; FLUSH entered only after the 8th accept.
- Reset mid-operation.
  - Stimulus: assert rst_n = 0 after 5 rows, then run a fresh block.
  - Response: out_valid = 0 immediately; no block_done; the next 8 rows form a clean block.
- With IDCT_ROW_SEQ_PINGPONG_EN defined.
  - Stimulus: 3 back-to-back blocks, out_ready = 1.
  - Response: in_ready never drops after the first block; blocks are output in order; steady-state period is 8 cycles.
